// File: rtl/gctrl_pkg.sv
// Shared types and default sizing for the gctrl_seq bit-serial sequencer.
package gctrl_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } gctrl_state_e;

    localparam int unsigned DEF_SEL_W  = 6;
    localparam int unsigned DEF_PASS_W = 3;
    localparam int unsigned DEF_LEN0   = 8;
    localparam int unsigned DEF_LEN1   = 12;
    localparam int unsigned DEF_LEN2   = 16;
    localparam int unsigned DEF_LEN3   = 24;

endpackage : gctrl_pkg

// File: rtl/gctrl_cnt.sv
// Modulo counter: counts 0..max_i with enable, synchronous clear and terminal-count flag.
module gctrl_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_c_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_c_o = (cnt_q == max_i);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_c_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : gctrl_cnt

// File: rtl/gctrl_seq.sv
// Bit-serial operation sequencer: walks sel over L bits per pass for npass passes.
// Optional negative-weight MSB flag enabled by macro GCTRL_SEQ_SIGN_EN.
module gctrl_seq
    import gctrl_pkg::*;
#(
    parameter int unsigned SEL_W  = DEF_SEL_W,
    parameter int unsigned PASS_W = DEF_PASS_W,
    parameter int unsigned LEN0   = DEF_LEN0,
    parameter int unsigned LEN1   = DEF_LEN1,
    parameter int unsigned LEN2   = DEF_LEN2,
    parameter int unsigned LEN3   = DEF_LEN3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [PASS_W-1:0] npass,
    input  logic              sign,
    input  logic              hold,
    input  logic              abort,
    output logic              ready,
    output logic              valid,
    output logic [SEL_W-1:0]  sel,
    output logic [PASS_W-1:0] pass,
    output logic              st,
    output logic              last,
    output logic              neg,
    output logic              done
);

    localparam int unsigned LEN_W = SEL_W + 1;

    gctrl_state_e      state_q;
    logic              done_q;
    logic [LEN_W-1:0]  len_q;
    logic [PASS_W-1:0] npass_q;
    logic [LEN_W-1:0]  len_sel_c;
    logic [SEL_W-1:0]  sel_max_c;
    logic [PASS_W-1:0] pass_max_c;
    logic              sel_tc_c;
    logic              pass_tc_c;
    logic              accept_c;
    logic              run_adv_c;
    logic              finish_c;

    always_comb begin
        len_sel_c = LEN_W'(LEN0);
        case (mode)
            2'd0:    len_sel_c = LEN_W'(LEN0);
            2'd1:    len_sel_c = LEN_W'(LEN1);
            2'd2:    len_sel_c = LEN_W'(LEN2);
            default: len_sel_c = LEN_W'(LEN3);
        endcase
    end

    // L can be 2^SEL_W, so the terminal index is taken from a one-bit-wider length.
    assign sel_max_c  = SEL_W'(len_q - LEN_W'(1));
    assign pass_max_c = npass_q - PASS_W'(1);

    assign accept_c  = start && (state_q == S_IDLE) && !abort;
    assign run_adv_c = (state_q == S_RUN) && !hold && !abort;
    assign finish_c  = run_adv_c && sel_tc_c && pass_tc_c;

    gctrl_cnt #(.W(SEL_W)) u_sel_cnt (
        .clk    (clk),
        .rstn   (rstn),
        .en_i   (run_adv_c),
        .clr_i  (abort),
        .max_i  (sel_max_c),
        .cnt_o  (sel),
        .tc_c_o (sel_tc_c)
    );

    gctrl_cnt #(.W(PASS_W)) u_pass_cnt (
        .clk    (clk),
        .rstn   (rstn),
        .en_i   (run_adv_c && sel_tc_c),
        .clr_i  (abort),
        .max_i  (pass_max_c),
        .cnt_o  (pass),
        .tc_c_o (pass_tc_c)
    );

`ifdef GCTRL_SEQ_SIGN_EN
    logic sign_q;
`else
    logic unused_sign;
    assign unused_sign = sign;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            len_q   <= '0;
            npass_q <= PASS_W'(1);
`ifdef GCTRL_SEQ_SIGN_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        state_q <= S_RUN;
                        len_q   <= len_sel_c;
                        npass_q <= (npass == '0) ? PASS_W'(1) : npass;
`ifdef GCTRL_SEQ_SIGN_EN
                        sign_q  <= sign;
`endif
                    end
                end
                S_RUN: begin
                    // Abort wins over hold and over completion of the final bit.
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else if (finish_c) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready = (state_q == S_IDLE);
    assign valid = (state_q == S_RUN) && !hold;
    assign st    = valid && (sel == '0);
    assign last  = valid && sel_tc_c;
    assign done  = done_q;

`ifdef GCTRL_SEQ_SIGN_EN
    assign neg = last && sign_q;
`else
    assign neg = 1'b0;
`endif

endmodule : gctrl_seq

// File: tb/tb_gctrl_seq.sv
// Randomized self-checking bench for gctrl_seq against a bit-list reference model.
module tb_gctrl_seq;

    localparam int SEL_W  = 6;
    localparam int PASS_W = 3;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic [1:0]        mode;
    logic [PASS_W-1:0] npass;
    logic              sign;
    logic              hold;
    logic              abort;
    logic              ready;
    logic              valid;
    logic [SEL_W-1:0]  sel;
    logic [PASS_W-1:0] pass;
    logic              st;
    logic              last;
    logic              neg;
    logic              done;

    typedef struct {
        int sel;
        int pass;
        bit st;
        bit last;
        bit neg;
    } bit_t;

    int checks = 0;
    int errors = 0;
    int lens[4] = '{8, 12, 16, 24};

    gctrl_seq dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .mode  (mode),
        .npass (npass),
        .sign  (sign),
        .hold  (hold),
        .abort (abort),
        .ready (ready),
        .valid (valid),
        .sel   (sel),
        .pass  (pass),
        .st    (st),
        .last  (last),
        .neg   (neg),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation; expected bit stream is every (pass, bit) pair in order.
    task automatic run_op(input int m, input int np_in, input bit sg, input int hold_pct,
                          input int hold_at, input int hold_n, input int kill_at,
                          input int kill_kind, input bit pre, input bit chain,
                          input int nm, input int nnp, input bit nsg,
                          output int run_cycles);
        bit_t q[$];
        bit_t e;
        int   len, np, idx, hn, err0;
        bit   killed, killing, ok;
        len = lens[m];
        np  = (np_in == 0) ? 1 : np_in;
        for (int p = 0; p < np; p++) begin
            for (int s = 0; s < len; s++) begin
                e.sel  = s;
                e.pass = p;
                e.st   = (s == 0);
                e.last = (s == len - 1);
`ifdef GCTRL_SEQ_SIGN_EN
                e.neg  = (s == len - 1) && sg;
`else
                e.neg  = 1'b0;
`endif
                q.push_back(e);
            end
        end
        if (!pre) begin
            mode = 2'(m); npass = PASS_W'(np_in); sign = sg;
            start = 1'b1; abort = 1'b0; hold = 1'($urandom_range(1));
            #1;
            checks++;
            if (ready !== 1'b1 || valid !== 1'b0)
                $display("FAIL start_idle ready=%b valid=%b expected ready=1 valid=0", ready, valid);
            if (ready !== 1'b1 || valid !== 1'b0) errors++;
            tick();
        end
        idx = 0; hn = 0; killed = 0; run_cycles = 0; err0 = errors; ok = 1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            hold  = ($urandom_range(99) < hold_pct);
            if (idx == hold_at && hn < hold_n) begin hold = 1'b1; hn++; end
            start = 1'($urandom_range(1));
            mode  = 2'($urandom); npass = PASS_W'($urandom); sign = 1'($urandom);
            abort = 1'b0; rstn = 1'b1;
            killing = (kill_at >= 0 && idx == kill_at);
            if (killing && kill_kind == 0) abort = 1'b1;
            if (killing && kill_kind == 1) rstn = 1'b0;
            #1;
            checks++;
            if (ready !== 1'b0 || done !== 1'b0) begin
                $display("FAIL busy ready=%b done=%b expected 0 0 at idx %0d", ready, done, idx);
                errors++;
            end
            checks++;
            if (valid !== !hold) begin
                $display("FAIL valid got %b expected %b at idx %0d", valid, !hold, idx);
                errors++;
            end
            if (!hold) begin
                e = q.pop_front();
                idx++;
                checks++;
                if ({sel, pass, st, last, neg} !== {SEL_W'(e.sel), PASS_W'(e.pass), e.st, e.last, e.neg}) begin
                    $display("FAIL bit got sel=%0d pass=%0d st=%b last=%b neg=%b expected sel=%0d pass=%0d st=%b last=%b neg=%b",
                             sel, pass, st, last, neg, e.sel, e.pass, e.st, e.last, e.neg);
                    errors++;
                end
            end else begin
                checks++;
                if ({st, last, neg} !== 3'b000 || sel !== SEL_W'(q[0].sel) || pass !== PASS_W'(q[0].pass)) begin
                    $display("FAIL hold got sel=%0d pass=%0d flags=%b%b%b expected sel=%0d pass=%0d flags=000",
                             sel, pass, st, last, neg, q[0].sel, q[0].pass);
                    errors++;
                end
            end
            run_cycles++;
            tick();
            if (killing) killed = 1;
            if (errors != err0) begin ok = 0; break; end
            if (q.size() == 0 || killed) break;
        end
        if (ok && q.size() != 0 && !killed) begin
            checks++; errors++;
            $display("FAIL timeout got %0d bits left expected 0", q.size());
            ok = 0;
        end
        if (!ok) begin
            rstn = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
            tick();
            rstn = 1'b1;
            return;
        end
        rstn = 1'b1; abort = 1'b0; hold = 1'($urandom_range(1));
        start = chain; mode = 2'(nm); npass = PASS_W'(nnp); sign = nsg;
        #1;
        checks++;
        if ({ready, valid, sel, pass, done} !== {1'b1, 1'b0, SEL_W'(0), PASS_W'(0), !killed}) begin
            $display("FAIL end got ready=%b valid=%b sel=%0d pass=%0d done=%b expected 1 0 0 0 %b",
                     ready, valid, sel, pass, done, !killed);
            errors++;
        end
        tick();
        start = 1'b0;
        if (!chain) begin
            #1;
            checks++;
            if (done !== 1'b0 || ready !== 1'b1) begin
                $display("FAIL done_pulse got done=%b ready=%b expected 0 1", done, ready);
                errors++;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b1; hold = 1'b1; abort = 1'b0;
        mode = 2'd0; npass = '0; sign = 1'b1;
        tick(); tick();
        checks++;
        if ({ready, valid, sel, pass, st, last, neg, done} !== {1'b1, 1'b0, SEL_W'(0), PASS_W'(0), 4'b0000}) begin
            $display("FAIL reset got ready=%b valid=%b sel=%0d pass=%0d st=%b last=%b neg=%b done=%b expected 1 0 0 0 0 0 0 0",
                     ready, valid, sel, pass, st, last, neg, done);
            errors++;
        end
        rstn = 1'b1; start = 1'b0; hold = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int rc;
        run_op(0, 1, 1'b0, 0, -1, 0, -1, 0, 1'b0, 1'b0, 0, 0, 1'b0, rc);
        checks++;
        if (rc !== 8) begin $display("FAIL basic_len got %0d expected 8", rc); errors++; end
        run_op(3, 2, 1'b0, 0, -1, 0, -1, 0, 1'b0, 1'b0, 0, 0, 1'b0, rc);
        checks++;
        if (rc !== 48) begin $display("FAIL two_pass_len got %0d expected 48", rc); errors++; end
    endtask

    task automatic test_hold();
        int rc;
        run_op(1, 1, 1'b0, 0, 5, 3, -1, 0, 1'b0, 1'b0, 0, 0, 1'b0, rc);
        checks++;
        if (rc !== 15) begin $display("FAIL hold_len got %0d expected 15", rc); errors++; end
    endtask

    task automatic test_sign();
        int rc;
        run_op(0, 1, 1'b1, 0, -1, 0, -1, 0, 1'b0, 1'b0, 0, 0, 1'b0, rc);
        run_op(2, 2, 1'b1, 20, -1, 0, -1, 0, 1'b0, 1'b0, 0, 0, 1'b0, rc);
    endtask

    task automatic test_back_to_back();
        int rc;
        run_op(2, 1, 1'b0, 0, -1, 0, -1, 0, 1'b0, 1'b1, 2, 3, 1'b0, rc);
        run_op(2, 3, 1'b0, 0, -1, 0, 20, 0, 1'b1, 1'b0, 0, 0, 1'b0, rc);
        checks++;
        if (rc !== 21) begin $display("FAIL abort_len got %0d expected 21", rc); errors++; end
    endtask

    task automatic test_idle_ignore();
        start = 1'b1; abort = 1'b1; hold = 1'b1; mode = 2'd1; npass = PASS_W'(2);
        tick();
        start = 1'b0; abort = 1'b0; hold = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || valid !== 1'b0 || done !== 1'b0) begin
            $display("FAIL idle_abort got ready=%b valid=%b done=%b expected 1 0 0", ready, valid, done);
            errors++;
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int rc;
        run_op(1, 2, 1'b1, 10, -1, 0, 7, 1, 1'b0, 1'b0, 0, 0, 1'b0, rc);
        run_op(0, 0, 1'b0, 0, -1, 0, -1, 0, 1'b0, 1'b0, 0, 0, 1'b0, rc);
        checks++;
        if (rc !== 8) begin $display("FAIL npass0_len got %0d expected 8", rc); errors++; end
    endtask

    task automatic test_random();
        int rc, m, np, nm, nnp, kill_at, kind;
        bit sg, nsg, pre, ch;
        nm = $urandom_range(3); nnp = $urandom_range(7); nsg = 1'($urandom);
        pre = 1'b0;
        for (int i = 0; i < 20; i++) begin
            m = nm; np = nnp; sg = nsg;
            nm = $urandom_range(3); nnp = $urandom_range(7); nsg = 1'($urandom);
            ch = 1'($urandom);
            kill_at = -1; kind = 0;
            if ($urandom_range(3) == 0) begin
                kill_at = $urandom_range(lens[m] * ((np == 0) ? 1 : np) - 1);
                kind = $urandom_range(1);
            end
            run_op(m, np, sg, 30, -1, 0, kill_at, kind, pre, ch, nm, nnp, nsg, rc);
            pre = ch;
        end
        if (pre) begin
            run_op(nm, nnp, nsg, 0, -1, 0, -1, 0, 1'b1, 1'b0, 0, 0, 1'b0, rc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_sign();
        test_back_to_back();
        test_idle_ignore();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gctrl_seq
